// File: rtl/ucie_pkg.sv
// Shared UCIe types and constants: CRC-32 generator/seed, CRC engine FSM states
// and a byte-wise reference CRC step (MSB-first register, data bit 0 first).
package ucie_pkg;

    localparam logic [31:0] UCIE_CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] UCIE_CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        CRC_IDLE,
        CRC_ACCUM,
        CRC_HOLD
    } crc_fsm_t;

    // One data byte, LSB first, no reflection and no final XOR.
    function automatic logic [31:0] calc_crc32(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) c = (c << 1) ^ UCIE_CRC32_POLY;
            else                 c = c << 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/ucie_crc_update.sv
// Combinational CRC update over one beat; only the low 8*nbytes bits are
// folded in, and nbytes==0 selects the whole beat.
module ucie_crc_update #(
    parameter int          DATA_WIDTH = 256,
    parameter int          CRC_WIDTH  = 32,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    localparam int         BW         = ((DATA_WIDTH / 8) > 1) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic [CRC_WIDTH-1:0]  crc_in,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [BW-1:0]         nbytes,
    output logic [CRC_WIDTH-1:0]  crc_out
);

    logic [31:0]          w_limit;
    logic [CRC_WIDTH-1:0] w_crc;

    always_comb begin
        w_limit = (nbytes == '0) ? 32'(DATA_WIDTH) : (32'(nbytes) << 3);
        w_crc   = crc_in;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (i < w_limit) begin
                if (w_crc[CRC_WIDTH-1] ^ data[i]) w_crc = (w_crc << 1) ^ POLY[CRC_WIDTH-1:0];
                else                               w_crc = w_crc << 1;
            end
        end
        crc_out = w_crc;
    end

endmodule

// File: rtl/ucie_crc_engine.sv
// Streaming frame CRC engine with optional check mode and result hold.
// Define UCIE_CRC_ERR_CNT_EN to add the saturating err_cnt mismatch counter.
module ucie_crc_engine
    import ucie_pkg::*;
#(
    parameter int          DATA_WIDTH = 256,
    parameter int          CRC_WIDTH  = 32,
    parameter logic [31:0] POLY       = UCIE_CRC32_POLY,
    parameter logic [31:0] CRC_INIT   = UCIE_CRC32_INIT,
    localparam int         BW         = ((DATA_WIDTH / 8) > 1) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [BW-1:0]         in_bytes,
    input  logic                  in_chk_en,
    input  logic [CRC_WIDTH-1:0]  in_exp_crc,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CRC_WIDTH-1:0]  res_crc,
    output logic                  res_err,
    output logic                  seq_err
`ifdef UCIE_CRC_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    crc_fsm_t             r_state;
    crc_fsm_t             w_state_nxt;
    logic [CRC_WIDTH-1:0] r_crc;
    logic [CRC_WIDTH-1:0] r_res_crc;
    logic                 r_res_err;
    logic                 r_seq_err;
    logic [CRC_WIDTH-1:0] w_seed;
    logic [CRC_WIDTH-1:0] w_crc_nxt;
    logic [BW-1:0]        w_nbytes;
    logic                 w_crc_we;
    logic                 w_res_we;
    logic                 w_seq_viol;

    // SOP always reseeds, which also covers the restart-on-SOP-mid-frame case.
    assign w_seed   = in_sop ? CRC_INIT[CRC_WIDTH-1:0] : r_crc;
    assign w_nbytes = in_eop ? in_bytes : '0;

    ucie_crc_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (CRC_WIDTH),
        .POLY       (POLY)
    ) u_update (
        .crc_in  (w_seed),
        .data    (in_data),
        .nbytes  (w_nbytes),
        .crc_out (w_crc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= CRC_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_crc_we    = 1'b0;
        w_res_we    = 1'b0;
        w_seq_viol  = 1'b0;
        unique case (r_state)
            CRC_IDLE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        w_crc_we    = 1'b1;
                        w_res_we    = in_eop;
                        w_state_nxt = in_eop ? CRC_HOLD : CRC_ACCUM;
                    end else begin
                        w_seq_viol = 1'b1;
                    end
                end
            end
            CRC_ACCUM: begin
                if (in_valid) begin
                    w_crc_we   = 1'b1;
                    w_seq_viol = in_sop;
                    if (in_eop) begin
                        w_res_we    = 1'b1;
                        w_state_nxt = CRC_HOLD;
                    end
                end
            end
            CRC_HOLD: begin
                if (res_ready) w_state_nxt = CRC_IDLE;
            end
            default: w_state_nxt = CRC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc     <= CRC_INIT[CRC_WIDTH-1:0];
            r_res_crc <= '0;
            r_res_err <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_seq_err <= w_seq_viol;
            if (w_crc_we) r_crc <= w_crc_nxt;
            if (w_res_we) begin
                r_res_crc <= w_crc_nxt;
                r_res_err <= in_chk_en & (w_crc_nxt != in_exp_crc);
            end
        end
    end

`ifdef UCIE_CRC_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_cnt_inc;

    assign w_cnt_inc = (r_state == CRC_HOLD) & res_ready & r_res_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           r_err_cnt <= '0;
        else if (w_cnt_inc && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

    assign in_ready  = (r_state != CRC_HOLD);
    assign res_valid = (r_state == CRC_HOLD);
    assign res_crc   = r_res_crc;
    assign res_err   = r_res_err;
    assign seq_err   = r_seq_err;

endmodule

// File: doc/ucie_crc_engine.md
UCIE_CRC_ENGINE -- requirements
Module: ucie_crc_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: beat width in bits, a multiple of 8, from 8 to 2048.
REQ-002 SHALL have parameter CRC_WIDTH, default 32: CRC register width, from 8 to 32.
REQ-003 SHALL have parameter POLY, default 32'h04C11DB7: generator polynomial; only the low CRC_WIDTH bits are used.
REQ-004 SHALL have parameter CRC_INIT, default 32'hFFFFFFFF: seed loaded on SOP; only the low CRC_WIDTH bits are used.
REQ-005 SHALL have derived localparam BW = $clog2(DATA_WIDTH/8), minimum 1.
REQ-006 Ports SHALL be as follows:
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- in_data  in  DATA_WIDTH  beat payload; bit 0 is processed first.
- in_sop  in  1  first beat of a frame.
- in_eop  in  1  last beat of a frame.
- in_bytes  in  BW  valid low-order bytes on the EOP beat; 0 means all bytes are valid.
- in_chk_en  in  1  check mode; sampled on the EOP beat.
- in_exp_crc  in  CRC_WIDTH  expected CRC; sampled on the EOP beat.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_crc  out  CRC_WIDTH  final CRC.
- res_err  out  1  check mismatch; meaningful only when res_valid is high.
- seq_err  out  1  one-cycle pulse on a framing violation.
- err_cnt  out  16  saturating mismatch count; present only when UCIE_CRC_ERR_CNT_EN is defined.

Function
REQ-007 The per-bit update SHALL be: if crc[MSB]^d then crc=(crc<<1)^POLY, else crc=crc<<1. There is no reflection and no final XOR, so the result is bit-identical to ucie_pkg::calc_crc32 at CRC_WIDTH=32.
REQ-008 Each accepted beat SHALL update the CRC in a single cycle, with DATA_WIDTH bits unrolled combinationally.
REQ-009 On an EOP beat, only bits [8*in_bytes-1:0] SHALL be processed; all DATA_WIDTH bits are processed when in_bytes==0. On non-EOP beats, in_bytes SHALL be ignored.
REQ-010 The FSM SHALL have states IDLE, ACCUM and HOLD.
- IDLE: SOP without EOP loads CRC_INIT and then the beat update, and moves to ACCUM. SOP with EOP produces a single-beat frame and moves to HOLD.
- ACCUM: a non-SOP beat accumulates. A beat with EOP moves to HOLD.
- HOLD: res_valid=1. On res_ready the FSM moves to IDLE.
REQ-011 A beat without SOP in IDLE SHALL be accepted and discarded, and seq_err SHALL pulse.
REQ-012 SOP in ACCUM SHALL abandon the current frame and restart from CRC_INIT with this beat, and seq_err SHALL pulse.
REQ-013 in_ready SHALL be 0 in HOLD and 1 otherwise. Consequently no beat is accepted in the cycle that res_ready is asserted; the next beat is taken the following cycle.
REQ-014 Latency: res_valid SHALL rise in the cycle after the EOP beat is accepted, with res_crc registered.
REQ-015 res_err SHALL equal in_chk_en & (crc != in_exp_crc), captured at EOP. It SHALL be 0 when check mode is off.
REQ-016 res_crc and res_err SHALL remain stable while res_valid=1 and res_ready=0.
REQ-017 in_valid=0 SHALL leave all state unchanged, including mid-frame.

Reset
REQ-018 Assertion of rst_n=0 SHALL immediately force: FSM=IDLE, CRC register=CRC_INIT, res_valid=0, res_crc=0, res_err=0, seq_err=0, err_cnt=0, in_ready=1 (combinational, because the FSM is IDLE). Reset has this effect in any state, including mid-frame and HOLD, and the partial frame is lost.

Configuration
REQ-019 When UCIE_CRC_ERR_CNT_EN is defined, err_cnt SHALL increment when a HOLD result with res_err=1 is consumed, and SHALL saturate at 16'hFFFF.
REQ-020 When UCIE_CRC_ERR_CNT_EN is undefined, the err_cnt port and its counter logic SHALL be absent.

Structure
REQ-021 ucie_pkg SHALL gain the constants UCIE_CRC32_POLY and UCIE_CRC32_INIT, and the enum crc_fsm_t {CRC_IDLE, CRC_ACCUM, CRC_HOLD}.
REQ-022 The byte-masked combinational beat update SHALL be in the sub-module ucie_crc_update, which has parameters DATA_WIDTH, CRC_WIDTH and POLY, and ports crc_in, data, nbytes and crc_out.

Verification
REQ-023 Seed and single beat: CRC_INIT=0, one SOP+EOP beat of all zeros with in_bytes=0 -> res_crc=0 one cycle later.
REQ-024 Multi-beat and partial final beat: 3-beat frame of random data, in_bytes=5 on EOP, with defaults -> res_crc equals calc_crc32(32'hFFFFFFFF, …) over 2*256+40 bits, fed sequentially.
REQ-025 Check mode: the same frame with in_chk_en=1, run once with a correct in_exp_crc and once with it flipped in bit 0 -> res_err=0, then res_err=1. With the macro defined -> err_cnt=1.
REQ-026 Backpressure: res_ready held at 0 for 10 cycles -> in_ready=0 and res_crc stable. The next frame's SOP is accepted the cycle after the handshake.
REQ-027 Framing: a non-SOP beat in IDLE, then an SOP mid-frame -> two seq_err pulses, and the result equals the CRC of the restarted frame only.
REQ-028 Reset mid-frame: rst_n=0 after beat 2 of a 4-beat frame -> outputs at their reset values. A following clean frame -> correct CRC.
